// File: rtl/minirv_pkg.sv
// Shared constants and types for the minirv integer datapath.
// Holds register-file geometry and the writeback arbiter state encoding.
package minirv_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HELD  = 1'b1
  } wb_state_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry address+data holding register.
// Parks an ALU result that lost arbitration to a load.
module wb_hold_slot
  import minirv_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // Load has priority over clear so a capture is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port
// and tracks registers with outstanding loads for load-use stalls.
module regfile_writeback_arbiter
  import minirv_pkg::*;
#(
  parameter int DATA_W = minirv_pkg::DATA_W,
  parameter int ADDR_W = minirv_pkg::ADDR_W,
  parameter int NREG   = minirv_pkg::NREG
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_mem_rd_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_mem_ready,
  input  logic              i_ld_issue,
  input  logic [ADDR_W-1:0] i_ld_issue_addr,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic              o_rs1_pending,
  output logic              o_rs2_pending,
  output logic [NREG-1:0]   o_pending_mask,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_reg_write
);

  wb_state_e         r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_reg_write;
  logic [NREG-1:0]   r_pending_mask;

  logic              w_empty;
  logic              w_mem_acc;
  logic              w_slot_load;
  logic              w_slot_valid;
  logic [ADDR_W-1:0] w_slot_addr;
  logic [DATA_W-1:0] w_slot_data;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;

  assign w_empty     = (r_state == WB_EMPTY);
  assign w_mem_acc   = w_empty && i_mem_valid;
  assign w_slot_load = w_empty && i_mem_valid && i_alu_valid;

  wb_hold_slot #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_alu_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_slot_load),
    .i_clear (!w_empty),
    .i_addr  (i_alu_rd_addr),
    .i_data  (i_alu_data),
    .o_valid (w_slot_valid),
    .o_addr  (w_slot_addr),
    .o_data  (w_slot_data)
  );

  // Loads win a collision; the losing ALU result drains from the slot next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= WB_EMPTY;
      r_reg_write <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        WB_EMPTY: begin
          if (i_mem_valid) begin
            r_rd_addr   <= i_mem_rd_addr;
            r_rd_data   <= i_mem_data;
            r_reg_write <= (i_mem_rd_addr != REG_ZERO);
            if (i_alu_valid) r_state <= WB_HELD;
          end else if (i_alu_valid) begin
            r_rd_addr   <= i_alu_rd_addr;
            r_rd_data   <= i_alu_data;
            r_reg_write <= (i_alu_rd_addr != REG_ZERO);
          end else begin
            r_reg_write <= 1'b0;
          end
        end
        WB_HELD: begin
          r_rd_addr   <= w_slot_addr;
          r_rd_data   <= w_slot_data;
          r_reg_write <= w_slot_valid && (w_slot_addr != REG_ZERO);
          r_state     <= WB_EMPTY;
        end
        default: r_state <= WB_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_ld_issue && (i_ld_issue_addr != REG_ZERO)) w_set[i_ld_issue_addr] = 1'b1;
    if (w_mem_acc) w_clr[i_mem_rd_addr] = 1'b1;
  end

  // A new issue to the same register outranks the returning load's clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending_mask <= '0;
    else          r_pending_mask <= (r_pending_mask & ~w_clr) | w_set;
  end

  assign o_alu_ready    = w_empty;
  assign o_mem_ready    = w_empty;
  assign o_rs1_pending  = r_pending_mask[i_rs1_addr];
  assign o_rs2_pending  = r_pending_mask[i_rs2_addr];
  assign o_pending_mask = r_pending_mask;
  assign o_rd_addr      = r_rd_addr;
  assign o_rd_data      = r_rd_data;
  assign o_reg_write    = r_reg_write;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios
// followed by random traffic against a queue-based writeback model.
module tb_regfile_writeback_arbiter;

  logic        clk;
  logic        rstN;
  logic        aluValid, memValid, ldIssue;
  logic [4:0]  aluAddr, memAddr, ldAddr, rs1Addr, rs2Addr;
  logic [31:0] aluData, memData;
  logic        aluReady, memReady, rs1Pend, rs2Pend, regWrite;
  logic [31:0] pendMask;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  // Model: accepted writes queue up in arrival order (load before ALU) and
  // drain one per cycle; offers are accepted only while nothing is backlogged.
  wr_t         writeQ[$];
  logic        expRw;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  logic [31:0] expMask;

  regfile_writeback_arbiter dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_alu_valid     (aluValid),
    .i_alu_rd_addr   (aluAddr),
    .i_alu_data      (aluData),
    .o_alu_ready     (aluReady),
    .i_mem_valid     (memValid),
    .i_mem_rd_addr   (memAddr),
    .i_mem_data      (memData),
    .o_mem_ready     (memReady),
    .i_ld_issue      (ldIssue),
    .i_ld_issue_addr (ldAddr),
    .i_rs1_addr      (rs1Addr),
    .i_rs2_addr      (rs2Addr),
    .o_rs1_pending   (rs1Pend),
    .o_rs2_pending   (rs2Pend),
    .o_pending_mask  (pendMask),
    .o_rd_addr       (rdAddr),
    .o_rd_data       (rdData),
    .o_reg_write     (regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic resetModel();
    writeQ.delete();
    expRw   = 1'b0;
    expAddr = '0;
    expData = '0;
    expMask = '0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".reg_write"}, regWrite, expRw);
    checkOutput({tag, ".rd_addr"}, rdAddr, expAddr);
    checkOutput({tag, ".rd_data"}, rdData, expData);
    checkOutput({tag, ".alu_ready"}, aluReady, writeQ.size() == 0);
    checkOutput({tag, ".mem_ready"}, memReady, writeQ.size() == 0);
    checkOutput({tag, ".pending_mask"}, pendMask, expMask);
  endtask

  // Called just after a falling edge: drive one cycle, step the model, check.
  task automatic applyStimulus(input string tag,
                               input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                               input logic mV, input logic [4:0] mA, input logic [31:0] mD,
                               input logic lI, input logic [4:0] lA,
                               input logic [4:0] r1, input logic [4:0] r2);
    wr_t e;
    aluValid = aV; aluAddr = aA; aluData = aD;
    memValid = mV; memAddr = mA; memData = mD;
    ldIssue  = lI; ldAddr  = lA;
    rs1Addr  = r1; rs2Addr = r2;
    #1;
    checkOutput({tag, ".rs1_pending"}, rs1Pend, expMask[r1]);
    checkOutput({tag, ".rs2_pending"}, rs2Pend, expMask[r2]);
    if (writeQ.size() == 0) begin
      if (mV) begin
        e.addr = mA; e.data = mD;
        writeQ.push_back(e);
        expMask[mA] = 1'b0;
      end
      if (aV) begin
        e.addr = aA; e.data = aD;
        writeQ.push_back(e);
      end
    end
    if (lI && lA != 5'd0) expMask[lA] = 1'b1;
    if (writeQ.size() > 0) begin
      e = writeQ.pop_front();
      expRw   = (e.addr != 5'd0);
      expAddr = e.addr;
      expData = e.data;
    end else begin
      expRw = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkState(tag);
  endtask

  task automatic idle(input string tag, input logic [4:0] r1);
    applyStimulus(tag, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, r1, 5'd0);
  endtask

  initial begin
    resetModel();
    rstN = 1'b0;
    aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'hDEAD;
    memValid = 1'b1; memAddr = 5'd6; memData = 32'hBEEF;
    ldIssue  = 1'b1; ldAddr  = 5'd8;
    rs1Addr  = 5'd8; rs2Addr = 5'd0;
    repeat (2) @(negedge clk);
    checkState("reset");

    rstN = 1'b1;
    applyStimulus("alu_only", 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("alu_only.const_rw", regWrite, 1'b1);
    checkOutput("alu_only.const_addr", rdAddr, 5'd5);
    checkOutput("alu_only.const_data", rdData, 32'h1234);

    applyStimulus("collide", 1, 5'd7, 32'h0000_5555, 1, 5'd3, 32'hAAAA_0000, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("collide.const_addr", rdAddr, 5'd3);
    checkOutput("collide.const_ready", aluReady, 1'b0);
    idle("collide_n2", 5'd0);
    checkOutput("collide_n2.const_addr", rdAddr, 5'd7);
    checkOutput("collide_n2.const_data", rdData, 32'h0000_5555);
    idle("collide_n3", 5'd0);
    checkOutput("collide_n3.const_ready", memReady, 1'b1);

    applyStimulus("ld9", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
    checkOutput("ld9.const_mask", pendMask[9], 1'b1);
    idle("ld9_rs1", 5'd9);
    applyStimulus("ld9_race", 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd9);
    checkOutput("ld9_race.const_mask", pendMask[9], 1'b1);
    applyStimulus("ld9_ret", 0, 5'd0, 32'd0, 1, 5'd9, 32'h77, 0, 5'd0, 5'd9, 5'd0);
    checkOutput("ld9_ret.const_mask", pendMask[9], 1'b0);

    applyStimulus("x0_alu", 1, 5'd0, 32'hCAFE, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_alu.const_rw", regWrite, 1'b0);
    applyStimulus("x0_ld", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_ld.const_mask", pendMask, 32'd0);

    applyStimulus("held_ld", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12, 5'd12, 5'd0);
    applyStimulus("held", 1, 5'd11, 32'h1111, 1, 5'd2, 32'h2222, 0, 5'd0, 5'd0, 5'd0);
    rstN = 1'b0;
    resetModel();
    #1;
    checkState("held_rst");
    @(negedge clk);
    rstN = 1'b1;
    idle("held_after", 5'd0);
    checkOutput("held_after.const_rw", regWrite, 1'b0);
    idle("held_after2", 5'd12);

    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
